// File: rtl/dm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dm_ctrl_if
// Description : Request / response / store-trace bundle between the MEM stage
//               and the data-memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface dm_ctrl_if;
    // Request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    // Response channel
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  resp_errcode;
    // Status and store trace
    logic        busy;
    logic        wlog_valid;
    logic [31:0] wlog_pc;
    logic [31:0] wlog_addr;
    logic [31:0] wlog_data;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_pc,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_errcode,
        input  busy, wlog_valid, wlog_pc, wlog_addr, wlog_data
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_pc,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_errcode,
        output busy, wlog_valid, wlog_pc, wlog_addr, wlog_data
    );
endinterface
`default_nettype wire

// File: rtl/dm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dm_ctrl
// Description : Multi-cycle data-memory controller for the MEM stage. One
//               request in flight, configurable latency, byte/half/word
//               stores with lane merge, sign/zero-extended loads, alignment
//               and range checking, post-reset clear sweep, store trace.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_ctrl #(
    parameter int          ADDR_W     = 12,
    parameter logic [31:0] BASE       = 32'h0000_0000,
    parameter logic [31:0] LIMIT      = 32'h0000_3000,
    parameter int          LATENCY    = 2,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  wire logic  clk,
    input  wire logic  reset,       // asynchronous, active low
    dm_ctrl_if.slave   bus
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [2:0] c_lat_m1 = 3'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam state_t c_rst_state = INIT_CLEAR ? S_CLEAR : S_IDLE;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [2:0]          cnt_q, cnt_d;

    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                sgn_q, sgn_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         pc_q, pc_d;

    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [1:0]          code_q, code_d;
    logic                wlog_valid_q, wlog_valid_d;
    logic [31:0]         wlog_pc_q, wlog_pc_d;
    logic [31:0]         wlog_addr_q, wlog_addr_d;
    logic [31:0]         wlog_data_q, wlog_data_d;

    logic [31:0]         mem_q [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [31:0]         mem_wdata;

    // ------------------------------------------------------------------------
    // Execute datapath, operating on the latched request
    // ------------------------------------------------------------------------
    logic [32:0]         w_diff;
    logic [31:0]         w_off;
    logic                w_below;
    logic [ADDR_W-1:0]   w_widx;
    logic [31:0]         w_old;
    logic [1:0]          w_code;
    logic [31:0]         w_merged;
    logic [31:0]         w_shift;
    logic [31:0]         w_load;
    logic                w_accept;
    logic                unused_off_bits;

    // The borrow of a 33-bit subtraction gives addr < BASE without a
    // comparison that degenerates when BASE is zero.
    assign w_diff  = {1'b0, addr_q} - {1'b0, BASE};
    assign w_off   = w_diff[31:0];
    assign w_below = w_diff[32];
    assign w_widx  = w_off[ADDR_W+1:2];
    assign w_old   = mem_q[w_widx];
    assign unused_off_bits = ^{w_off[31:ADDR_W+2], w_off[1:0]};

    assign w_accept = bus.req_valid & ready_q;

    // Error classification, lane merge and load extraction
    always_comb begin
        w_code   = 2'b00;
        w_merged = w_old;
        w_shift  = w_old >> {addr_q[1:0], 3'b000};
        w_load   = w_old;

        if (size_q == 2'b11) begin
            w_code = 2'b11;
        end else if ((size_q == 2'b01 && addr_q[0]) ||
                     (size_q == 2'b10 && addr_q[1:0] != 2'b00)) begin
            w_code = 2'b01;
        end else if (w_below || addr_q >= LIMIT) begin
            w_code = 2'b10;
        end

        case (size_q)
            2'b00: begin
                w_merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
                w_load = sgn_q ? {{24{w_shift[7]}}, w_shift[7:0]}
                               : {24'd0, w_shift[7:0]};
            end
            2'b01: begin
                w_merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
                w_load = sgn_q ? {{16{w_shift[15]}}, w_shift[15:0]}
                               : {16'd0, w_shift[15:0]};
            end
            default: begin
                w_merged = wdata_q;
                w_load   = w_old;
            end
        endcase
    end

    // Next-state, request capture, response and memory-write control
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        pc_d         = pc_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        code_d       = code_q;
        wlog_valid_d = 1'b0;
        wlog_pc_d    = wlog_pc_q;
        wlog_addr_d  = wlog_addr_q;
        wlog_data_d  = wlog_data_q;
        mem_we       = 1'b0;
        mem_waddr    = w_widx;
        mem_wdata    = w_merged;

        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = idx_q;
                mem_wdata = 32'd0;
                idx_d     = idx_q + 1'b1;
                if (&idx_q) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE, S_RESP: begin
                if (w_accept) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    sgn_d   = bus.req_signed;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    pc_d    = bus.req_pc;
                    cnt_d   = c_lat_m1;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    err_d        = (w_code != 2'b00);
                    code_d       = w_code;
                    rdata_d      = (w_code == 2'b00 && !we_q) ? w_load : 32'd0;
                    if (w_code == 2'b00 && we_q) begin
                        mem_we       = 1'b1;
                        wlog_valid_d = 1'b1;
                        wlog_pc_d    = pc_q;
                        wlog_addr_d  = {addr_q[31:2], 2'b00};
                        wlog_data_d  = w_merged;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE) || (state_d == S_RESP);
        busy_d  = (state_d == S_CLEAR);
    end

    // Control and output registers; reset drops any in-flight request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= c_rst_state;
            idx_q        <= '0;
            cnt_q        <= 3'd0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            sgn_q        <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            pc_q         <= 32'd0;
            ready_q      <= 1'b0;
            busy_q       <= INIT_CLEAR;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
            code_q       <= 2'b00;
            wlog_valid_q <= 1'b0;
            wlog_pc_q    <= 32'd0;
            wlog_addr_q  <= 32'd0;
            wlog_data_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            pc_q         <= pc_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            code_q       <= code_d;
            wlog_valid_q <= wlog_valid_d;
            wlog_pc_q    <= wlog_pc_d;
            wlog_addr_q  <= wlog_addr_d;
            wlog_data_q  <= wlog_data_d;
        end
    end

    // Storage array: no reset, contents are initialised by the clear sweep
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.req_ready    = ready_q;
    assign bus.busy         = busy_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rdata   = rdata_q;
    assign bus.resp_err     = err_q;
    assign bus.resp_errcode = code_q;
    assign bus.wlog_valid   = wlog_valid_q;
    assign bus.wlog_pc      = wlog_pc_q;
    assign bus.wlog_addr    = wlog_addr_q;
    assign bus.wlog_data    = wlog_data_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_ctrl
// Description : Scoreboard bench for dm_ctrl (ADDR_W=4, LIMIT=0x40, LATENCY=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_ctrl;

    localparam int          ADDR_W  = 4;
    localparam logic [31:0] LIMIT   = 32'h0000_0040;
    localparam int          LATENCY = 3;

    typedef struct {
        logic        err;
        logic [1:0]  code;
        logic [31:0] rdata;
        logic        wv;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] wp;
        int          acc;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   edge_cnt;
    int   pc_seq;
    exp_t sbq[$];

    dm_ctrl_if dif();

    dm_ctrl #(
        .ADDR_W     (ADDR_W),
        .BASE       (32'h0000_0000),
        .LIMIT      (LIMIT),
        .LATENCY    (LATENCY),
        .INIT_CLEAR (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: pops one expectation per response pulse
    always @(negedge clk) begin
        exp_t e;
        if (dif.resp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected none (addr phase edge %0d)", edge_cnt);
            end else begin
                e = sbq.pop_front();
                chk("latency",  32'(edge_cnt - e.acc), 32'(LATENCY));
                chk("resp_err", {31'd0, dif.resp_err}, {31'd0, e.err});
                chk("errcode",  {30'd0, dif.resp_errcode}, {30'd0, e.code});
                chk("rdata",    dif.resp_rdata, e.rdata);
                chk("wlog_valid", {31'd0, dif.wlog_valid}, {31'd0, e.wv});
                if (e.wv) begin
                    chk("wlog_addr", dif.wlog_addr, e.wa);
                    chk("wlog_data", dif.wlog_data, e.wd);
                    chk("wlog_pc",   dif.wlog_pc,   e.wp);
                end
            end
        end else if (dif.wlog_valid === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL lone_wlog: got wlog_valid=1 expected 0 without resp_valid");
        end
    end

    // Drive one request from a negedge; returns at the negedge after acceptance
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic e_err, input logic [1:0] e_code,
                         input logic [31:0] e_rdata, input logic e_wv,
                         input logic [31:0] e_wa, input logic [31:0] e_wd,
                         output int acc);
        exp_t e;
        int   n;
        pc_seq += 4;
        dif.req_valid  = 1'b1;
        dif.req_we     = we;
        dif.req_size   = size;
        dif.req_signed = sgn;
        dif.req_addr   = addr;
        dif.req_wdata  = wdata;
        dif.req_pc     = 32'h0040_0000 + 32'(pc_seq);
        n = 0;
        while (dif.req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        acc = edge_cnt + 1;
        if (dif.req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=%b expected 1 within 200 cycles", dif.req_ready);
            dif.req_valid = 1'b0;
            return;
        end
        e.err = e_err; e.code = e_code; e.rdata = e_rdata;
        e.wv = e_wv; e.wa = e_wa; e.wd = e_wd; e.wp = dif.req_pc; e.acc = acc;
        sbq.push_back(e);
        @(negedge clk);
        dif.req_valid = 1'b0;
    endtask

    task automatic ld(input logic [31:0] addr, input logic [1:0] size,
                      input logic sgn, input logic [31:0] exp_rd);
        int a;
        issue(1'b0, size, sgn, addr, 32'd0, 1'b0, 2'b00, exp_rd, 1'b0, 32'd0, 32'd0, a);
    endtask

    task automatic st(input logic [31:0] addr, input logic [1:0] size,
                      input logic [31:0] wd, input logic [31:0] exp_wa,
                      input logic [31:0] exp_wd);
        int a;
        issue(1'b1, size, 1'b0, addr, wd, 1'b0, 2'b00, 32'd0, 1'b1, exp_wa, exp_wd, a);
    endtask

    task automatic bad(input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [1:0] code);
        int a;
        issue(we, size, 1'b0, addr, 32'hFFFF_FFFF, 1'b1, code, 32'd0, 1'b0, 32'd0, 32'd0, a);
    endtask

    // Release reset at a negedge and measure the busy window of the sweep
    task automatic release_and_sweep();
        int n;
        reset = 1'b1;
        n = 0;
        while (dif.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("sweep_cycles", 32'(n), 32'd16);
        chk("ready_after_sweep", {31'd0, dif.req_ready}, 32'd1);
    endtask

    task automatic reset_outputs_check();
        chk("rst_busy",       {31'd0, dif.busy}, 32'd1);
        chk("rst_ready",      {31'd0, dif.req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, dif.resp_valid}, 32'd0);
        chk("rst_rdata",      dif.resp_rdata, 32'd0);
        chk("rst_wlog_valid", {31'd0, dif.wlog_valid}, 32'd0);
    endtask

    initial begin
        int a0, a1, n;
        checks = 0; errors = 0; edge_cnt = 0; pc_seq = 0;
        reset = 1'b0;
        dif.req_valid = 1'b0; dif.req_we = 1'b0; dif.req_size = 2'b00;
        dif.req_signed = 1'b0; dif.req_addr = 32'd0; dif.req_wdata = 32'd0;
        dif.req_pc = 32'd0;
        repeat (3) @(negedge clk);
        reset_outputs_check();
        release_and_sweep();

        // Every word reads back zero after the sweep
        for (int w = 0; w < 16; w++) ld(32'(w * 4), 2'b10, 1'b0, 32'd0);

        // Lane merge and extension
        st(32'h10, 2'b10, 32'h1234_5678, 32'h10, 32'h1234_5678);
        st(32'h11, 2'b00, 32'h0000_00AB, 32'h10, 32'h1234_AB78);
        ld(32'h11, 2'b00, 1'b1, 32'hFFFF_FFAB);
        ld(32'h11, 2'b00, 1'b0, 32'h0000_00AB);
        ld(32'h10, 2'b10, 1'b1, 32'h1234_AB78);
        st(32'h22, 2'b01, 32'h0000_8001, 32'h20, 32'h8001_0000);
        ld(32'h22, 2'b01, 1'b1, 32'hFFFF_8001);
        ld(32'h22, 2'b01, 1'b0, 32'h0000_8001);
        ld(32'h20, 2'b10, 1'b0, 32'h8001_0000);
        st(32'h27, 2'b00, 32'hFFFF_FF80, 32'h24, 32'h8000_0000);
        ld(32'h27, 2'b00, 1'b1, 32'hFFFF_FF80);

        // Error paths
        bad(1'b0, 2'b10, 32'h13, 2'b01);
        bad(1'b1, 2'b01, 32'h21, 2'b01);
        bad(1'b1, 2'b10, LIMIT, 2'b10);
        ld(32'h00, 2'b10, 1'b0, 32'd0);           // aliased word untouched
        bad(1'b1, 2'b11, 32'h10, 2'b11);
        bad(1'b0, 2'b11, 32'h41, 2'b11);          // size outranks other errors
        ld(32'h10, 2'b10, 1'b0, 32'h1234_AB78);

        // Back-to-back: second request held during WAIT, accepted in RESP
        issue(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE_F00D, 1'b0, 2'b00, 32'd0,
              1'b1, 32'h30, 32'hCAFE_F00D, a0);
        issue(1'b0, 2'b10, 1'b0, 32'h30, 32'd0, 1'b0, 2'b00, 32'hCAFE_F00D,
              1'b0, 32'd0, 32'd0, a1);
        chk("b2b_gap", 32'(a1 - a0), 32'(LATENCY + 1));

        // Reset two cycles into a store's WAIT drops it
        issue(1'b1, 2'b10, 1'b0, 32'h34, 32'hDEAD_BEEF, 1'b0, 2'b00, 32'd0,
              1'b1, 32'h34, 32'hDEAD_BEEF, a0);
        void'(sbq.pop_back());
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset_outputs_check();
        @(negedge clk);
        release_and_sweep();
        ld(32'h34, 2'b10, 1'b0, 32'd0);
        ld(32'h10, 2'b10, 1'b0, 32'd0);

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sbq.size()), 32'd0);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
